// File: rtl/seg_scan_if.sv
// -----------------------------------------------------------------------------
// seg_scan_if
// Bundle between a core (master) and the 7-segment scanner (slave).
//   d        core -> scanner   hex data, digit i = d[4i+3:4i], digit 0 rightmost
//   dp       core -> scanner   decimal point per digit, 1 = lit
//   en_mask  core -> scanner   per-digit enable, 0 = blanked (live)
//   load     core -> scanner   1-cycle pulse, capture d/dp as pending update
//   upd_ack  scanner -> core   1-cycle pulse, pending data now on display
//   an       scanner -> pins   digit select, active-low
//   cn       scanner -> pins   segments {g,f,e,d,c,b,a}, active-low
//   dp_n     scanner -> pins   decimal point, active-low
// -----------------------------------------------------------------------------
interface seg_scan_if #(
    parameter int NDIG = 8
);
    logic [4*NDIG-1:0] d;
    logic [NDIG-1:0]   dp;
    logic [NDIG-1:0]   en_mask;
    logic              load;
    logic              upd_ack;
    logic [NDIG-1:0]   an;
    logic [6:0]        cn;
    logic              dp_n;

    modport master (
        output d, dp, en_mask, load,
        input  upd_ack, an, cn, dp_n
    );

    modport slave (
        input  d, dp, en_mask, load,
        output upd_ack, an, cn, dp_n
    );
endinterface

// File: rtl/seg_scan_display.sv
// -----------------------------------------------------------------------------
// seg_scan_display
// Multiplexed common-anode 7-segment scanner for NDIG digits with an internal
// prescaler, per-digit enable, decimal points and a shadow-register update
// handshake: loaded data is only promoted to the displayed set at a frame
// boundary, so a frame never mixes old and new digits.
//
// Ports:
//   clk   system clock, posedge
//   rstn  asynchronous active-low reset
//   bus   seg_scan_if.slave (d, dp, en_mask, load in; upd_ack, an, cn, dp_n out)
//
// Parameters: NDIG (2..16 digits), DIV (clk cycles per digit slot, >=2).
//
// Optional feature: define SEG_LZB_EN for leading-zero blanking of the
// active data (digit 0 always shown, a lit dp on a digit or any lower digit
// keeps it visible). Without the macro no blanking logic is built.
// -----------------------------------------------------------------------------
module seg_scan_display #(
    parameter int NDIG = 8,
    parameter int DIV  = 100000
) (
    input  logic        clk,
    input  logic        rstn,
    seg_scan_if.slave   bus
);
    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(NDIG);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NDIG - 1);

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [4*NDIG-1:0] act_dat_q, act_dat_d;
    logic [NDIG-1:0]   act_dp_q, act_dp_d;
    logic [4*NDIG-1:0] pnd_dat_q, pnd_dat_d;
    logic [NDIG-1:0]   pnd_dp_q, pnd_dp_d;
    logic              pend_q, pend_d;
    logic              ack_q, ack_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic [6:0]        cn_q, cn_d;
    logic              dpn_q, dpn_d;

    logic              tick;
    logic              wrap;
    logic [3:0]        nib;
    logic              show;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Prescaler and digit index; the tick that wraps idx is the frame boundary.
    always_comb begin
        tick  = (cnt_q == CNT_MAX);
        wrap  = tick && (idx_q == IDX_MAX);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
    end

    // Shadow update: a load on the boundary tick bypasses the pending
    // register, otherwise a pending update is promoted at the boundary.
    always_comb begin
        act_dat_d = act_dat_q;
        act_dp_d  = act_dp_q;
        pnd_dat_d = pnd_dat_q;
        pnd_dp_d  = pnd_dp_q;
        pend_d    = pend_q;
        ack_d     = 1'b0;
        if (wrap && (bus.load || pend_q)) begin
            act_dat_d = bus.load ? bus.d  : pnd_dat_q;
            act_dp_d  = bus.load ? bus.dp : pnd_dp_q;
            pend_d    = 1'b0;
            ack_d     = 1'b1;
        end else if (bus.load) begin
            pnd_dat_d = bus.d;
            pnd_dp_d  = bus.dp;
            pend_d    = 1'b1;
        end
    end

`ifdef SEG_LZB_EN
    logic nz_at_or_above;
    logic dp_at_or_below;

    // A digit survives blanking if a nonzero nibble sits at or above it, or a
    // lit dp sits at or below it.
    always_comb begin
        nz_at_or_above = 1'b0;
        dp_at_or_below = 1'b0;
        for (int j = 0; j < NDIG; j++) begin
            if ((j >= int'(idx_q)) && (act_dat_q[4*j +: 4] != 4'h0)) nz_at_or_above = 1'b1;
            if ((j <= int'(idx_q)) && act_dp_q[j])                   dp_at_or_below = 1'b1;
        end
    end
`endif

    // Output decode, registered one clk behind idx.
    always_comb begin
        nib  = act_dat_q[{idx_q, 2'b00} +: 4];
        show = bus.en_mask[idx_q];
`ifdef SEG_LZB_EN
        show = show && ((idx_q == '0) || nz_at_or_above || dp_at_or_below);
`endif
        an_d  = '1;
        cn_d  = 7'h7F;
        dpn_d = 1'b1;
        if (show) begin
            an_d[idx_q] = 1'b0;
            cn_d        = hex_to_seg(nib);
            dpn_d       = ~act_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            act_dat_q <= '0;
            act_dp_q  <= '0;
            pnd_dat_q <= '0;
            pnd_dp_q  <= '0;
            pend_q    <= 1'b0;
            ack_q     <= 1'b0;
            an_q      <= '1;
            cn_q      <= 7'h7F;
            dpn_q     <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            act_dat_q <= act_dat_d;
            act_dp_q  <= act_dp_d;
            pnd_dat_q <= pnd_dat_d;
            pnd_dp_q  <= pnd_dp_d;
            pend_q    <= pend_d;
            ack_q     <= ack_d;
            an_q      <= an_d;
            cn_q      <= cn_d;
            dpn_q     <= dpn_d;
        end
    end

    assign bus.an      = an_q;
    assign bus.cn      = cn_q;
    assign bus.dp_n    = dpn_q;
    assign bus.upd_ack = ack_q;
endmodule

// File: tb/tb_seg_scan_display.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_display
// Bench for seg_scan_display at NDIG=8, DIV=4. A cycle model derives the
// expected display from the number of clock edges since reset release, and
// literal expectations at chosen frame phases pin the model.
// -----------------------------------------------------------------------------
module tb_seg_scan_display;
    localparam int NDIG  = 8;
    localparam int DIV   = 4;
    localparam int FRAME = NDIG * DIV;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    seg_scan_if #(.NDIG(NDIG)) bus ();

    seg_scan_display #(.NDIG(NDIG), .DIV(DIV)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;
    int ack_count = 0;

    logic [31:0]     m_act, m_pnd;
    logic [NDIG-1:0] m_act_dp, m_pnd_dp;
    bit              m_pend;
    logic [NDIG-1:0] exp_an;
    logic [6:0]      exp_cn;
    logic            exp_dpn, exp_ack;

    int              slot, hi;
    bit              wrap_now, shown, dpl;
    logic [31:0]     s_d;
    logic [NDIG-1:0] s_dp, s_en;
    logic            s_load;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model: slot on display after edge k+1 is floor(k/DIV) mod NDIG; frame
    // boundary edges are the multiples of FRAME.
    always @(posedge clk) begin
        s_d = bus.d; s_dp = bus.dp; s_en = bus.en_mask; s_load = bus.load;
        if (!rstn) begin
            k = 0; m_act = '0; m_pnd = '0; m_act_dp = '0; m_pnd_dp = '0; m_pend = 0;
            exp_an = '1; exp_cn = 7'h7F; exp_dpn = 1'b1; exp_ack = 1'b0;
        end else begin
            slot     = (k / DIV) % NDIG;
            wrap_now = ((k + 1) % FRAME) == 0;
            shown    = s_en[slot];
`ifdef SEG_LZB_EN
            hi = 0; dpl = 0;
            for (int j = 0; j < NDIG; j++) begin
                if (m_act[4*j +: 4] != 4'h0) hi = j;
                if (j <= slot && m_act_dp[j]) dpl = 1;
            end
            if (!(slot == 0 || slot <= hi || dpl)) shown = 0;
`endif
            exp_an = '1; exp_cn = 7'h7F; exp_dpn = 1'b1;
            if (shown) begin
                exp_an[slot] = 1'b0;
                exp_cn       = SEG_TAB[m_act[4*slot +: 4]];
                exp_dpn      = ~m_act_dp[slot];
            end
            exp_ack = wrap_now && (s_load || m_pend);
            if (wrap_now && s_load) begin
                m_act = s_d; m_act_dp = s_dp; m_pend = 0;
            end else if (wrap_now && m_pend) begin
                m_act = m_pnd; m_act_dp = m_pnd_dp; m_pend = 0;
            end else if (s_load) begin
                m_pnd = s_d; m_pnd_dp = s_dp; m_pend = 1;
            end
            k++;
        end
        #1;
        check("an",      32'(bus.an),      32'(exp_an));
        check("cn",      32'(bus.cn),      32'(exp_cn));
        check("dp_n",    32'(bus.dp_n),    32'(exp_dpn));
        check("upd_ack", 32'(bus.upd_ack), 32'(exp_ack));
        if (bus.upd_ack === 1'b1) ack_count++;
    end

    // Advance to the negedge where k mod FRAME equals ph.
    task automatic goto(input int ph);
        int b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (((k % FRAME) != ph) && (b < 4 * FRAME));
        check("goto_phase", 32'(k % FRAME), 32'(ph));
    endtask

    task automatic do_load(input logic [31:0] dat, input logic [NDIG-1:0] dpv);
        bus.d = dat; bus.dp = dpv; bus.load = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    initial begin
        int a0;
        bus.d = '0; bus.dp = '0; bus.en_mask = '1; bus.load = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_an", 32'(bus.an), 32'hFF);
        check("rst_cn", 32'(bus.cn), 32'h7F);
        check("rst_ack", 32'(bus.upd_ack), 32'h0);
        rstn = 1'b1;

        // No load: zeros scanning FE, FD, ...
        @(negedge clk);
        check("first_an", 32'(bus.an), 32'hFE);
        check("first_cn", 32'(bus.cn), 32'h40);
        goto(5);
        check("slot1_an", 32'(bus.an), 32'hFD);
        goto(29);
        check("slot7_an", 32'(bus.an), 32'h7F);
        goto(20);
        check("no_load_ack", 32'(ack_count), 32'h0);

        // Mid-frame load, promoted at the next boundary.
        goto(10);
        do_load(32'h1234ABCD, '0);
        goto(20);
        check("held_cn", 32'(bus.cn), 32'h40);
        goto(0);
        check("ack_after_wrap", 32'(bus.upd_ack), 32'h1);
        goto(1);
        check("slot0_d", 32'(bus.cn), 32'h21);
        goto(29);
        check("slot7_1", 32'(bus.cn), 32'h79);

        // Two loads in one frame: last wins, one ack.
        goto(5);
        a0 = ack_count;
        do_load(32'h11111111, '0);
        goto(12);
        do_load(32'h22222222, '0);
        goto(2);
        check("single_ack", 32'(ack_count - a0), 32'h1);
        check("twos_cn", 32'(bus.cn), 32'h24);

        // Load exactly on the boundary tick.
        goto(31);
        do_load(32'h00000005, 8'h01);
        check("wrap_load_ack", 32'(bus.upd_ack), 32'h1);
        goto(1);
        check("wrap_load_cn", 32'(bus.cn), 32'h12);
        check("dp0_lit", 32'(bus.dp_n), 32'h0);

        // Enable mask: upper four digits blanked.
        bus.en_mask = 8'h0F;
        goto(17);
        check("masked_an", 32'(bus.an), 32'hFF);
        goto(1);
        check("unmasked_dp", 32'(bus.dp_n), 32'h0);
        bus.en_mask = '1;

`ifdef SEG_LZB_EN
        goto(31);
        do_load(32'h00000305, '0);
        goto(13);
        check("lzb_slot3", 32'(bus.an), 32'hFF);
        goto(9);
        check("lzb_slot2", 32'(bus.an), 32'hFB);
        goto(31);
        do_load(32'h00000000, '0);
        goto(5);
        check("lzb_zero_slot1", 32'(bus.an), 32'hFF);
        goto(1);
        check("lzb_zero_slot0", 32'(bus.cn), 32'h40);
`else
        goto(31);
        do_load(32'h00000305, '0);
        goto(13);
        check("nolzb_slot3_an", 32'(bus.an), 32'hF7);
        check("nolzb_slot3_cn", 32'(bus.cn), 32'h40);
`endif

        // Async reset with a pending update.
        goto(6);
        do_load(32'h77777777, '0);
        goto(9);
        a0 = ack_count;
        rstn = 1'b0;
        #1;
        check("async_blank", 32'(bus.an), 32'hFF);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2 * FRAME + 3) @(negedge clk);
        check("no_ack_after_rst", 32'(ack_count - a0), 32'h0);
        goto(1);
        check("post_rst_cn", 32'(bus.cn), 32'h40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
